knight_cmd_sequencer: RTL

Parametrised command scripter that queues 16-bit Knight commands and issues them one at a time to the UART remote-comm transmitter. For each command it waits for cmd_snt, then for a response byte. 0xA5 (move done) advances to the next command. 0x5A (in progress) keeps waiting. Any other byte, a timeout, or an abort stops the script with an error code. It sits between a host/script source and the RemoteComm instance, and replaces hand-sequenced send/ack-check logic.

---
 rtl/knight_cmd_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/knight_cmd_sequencer.sv
// Command scripter: queues 16-bit Knight commands and issues them one at a time to RemoteComm.
// Each command waits for cmd_snt, then a response byte; done/busy/timeout/abort are tracked.
module knight_cmd_sequencer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TIMEOUT  = 7000000,
    parameter logic [7:0]  ACK_DONE = 8'hA5,
    parameter logic [7:0]  ACK_BUSY = 8'h5A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [15:0]              push_cmd,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     start,
    input  logic                     abort,
    output logic [15:0]              cmd,
    output logic                     snd_cmd,
    input  logic                     cmd_snt,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [7:0]               n_acked
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StSend, StWaitSnt, StWaitResp, StDone, StErr
    } state_t;

    state_t          r_state;
    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_cmd;
    logic [TW-1:0]   r_timer;
    logic [1:0]      r_err_code;
    logic [7:0]      r_n_acked;

    logic            w_full;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_timeout;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push_ok = push && !w_full;
    assign w_pop     = (r_state == StLoad) && !abort;
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    // Storage needs no reset: contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (abort) begin
            // Flush wins over a same-cycle push.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cmd      <= '0;
            r_timer    <= '0;
            r_err_code <= 2'd0;
            r_n_acked  <= '0;
        end else if (abort && (r_state != StIdle)) begin
            r_state    <= StErr;
            r_err_code <= 2'd3;
        end else begin
            case (r_state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        r_err_code <= 2'd0;
                        r_n_acked  <= '0;
                        r_state    <= (r_count != '0) ? StLoad : StDone;
                    end
                end
                StLoad: begin
                    r_cmd   <= r_mem[r_rd_ptr];
                    r_state <= StSend;
                end
                StSend: begin
                    r_timer <= '0;
                    r_state <= StWaitSnt;
                end
                StWaitSnt: begin
                    if (cmd_snt) begin
                        r_timer <= '0;
                        r_state <= StWaitResp;
                    end else if (w_timeout) begin
                        r_err_code <= 2'd1;
                        r_state    <= StErr;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                StWaitResp: begin
                    if (resp_rdy && (resp == ACK_DONE)) begin
                        if (r_n_acked != 8'hFF) begin
                            r_n_acked <= r_n_acked + 8'd1;
                        end
                        r_state <= (r_count != '0) ? StLoad : StDone;
                    end else if (resp_rdy && (resp == ACK_BUSY)) begin
                        r_timer <= '0;
                    end else if (resp_rdy) begin
                        r_err_code <= 2'd2;
                        r_state    <= StErr;
                    end else if (w_timeout) begin
                        r_err_code <= 2'd1;
                        r_state    <= StErr;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign full     = w_full;
    assign count    = r_count;
    assign cmd      = r_cmd;
    assign snd_cmd  = (r_state == StSend);
    assign busy     = (r_state == StLoad) || (r_state == StSend) ||
                      (r_state == StWaitSnt) || (r_state == StWaitResp);
    assign done     = (r_state == StDone);
    assign err      = (r_state == StErr);
    assign err_code = r_err_code;
    assign n_acked  = r_n_acked;

endmodule
